// File: rtl/aes_kat_checker.sv
// AES-128 known-answer-test sequencer: issues ROM vectors to a core, checks results with timeout, accumulates status.
// Optional build macro AES_KAT_STOP_ON_FAIL_EN ends the run at the first failing vector.
`timescale 1ns/1ps
module aes_kat_checker #(
    parameter  int unsigned NUM_VECTORS    = 4,
    parameter  int unsigned TIMEOUT_CYCLES = 64,
    parameter  int unsigned DATA_W         = 128,
    localparam int unsigned IDX_W          = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IDX_W-1:0]  vec_idx,
    input  logic [DATA_W-1:0] vec_key,
    input  logic [DATA_W-1:0] vec_pt,
    input  logic [DATA_W-1:0] vec_ct,
    output logic              aes_req,
    output logic [DATA_W-1:0] aes_key,
    output logic [DATA_W-1:0] aes_pt,
    input  logic              aes_valid,
    input  logic [DATA_W-1:0] aes_ct,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W:0]    fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic              timeout_flag
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    vec_idx_q, vec_idx_d;
    logic [DATA_W-1:0]   aes_key_q, aes_key_d;
    logic [DATA_W-1:0]   aes_pt_q, aes_pt_d;
    logic                aes_req_q, aes_req_d;
    logic [DATA_W-1:0]   ct_q, ct_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                to_hit_q, to_hit_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    fail_count_q, fail_count_d;
    logic [IDX_W-1:0]    first_fail_idx_q, first_fail_idx_d;
    logic                timeout_flag_q, timeout_flag_d;

    logic                last_c;
    logic                mismatch_c;
    logic                stop_c;

    assign last_c     = (vec_idx_q == IDX_W'(NUM_VECTORS - 1));
    // A timed-out vector is always a failure, whatever stale value ct_q holds.
    assign mismatch_c = to_hit_q || (ct_q != vec_ct);

`ifdef AES_KAT_STOP_ON_FAIL_EN
    assign stop_c = mismatch_c;
`else
    assign stop_c = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        vec_idx_d        = vec_idx_q;
        aes_key_d        = aes_key_q;
        aes_pt_d         = aes_pt_q;
        ct_d             = ct_q;
        tmo_d            = tmo_q;
        to_hit_d         = to_hit_q;
        fail_count_d     = fail_count_q;
        first_fail_idx_d = first_fail_idx_q;
        timeout_flag_d   = timeout_flag_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d          = S_ISSUE;
                    vec_idx_d        = '0;
                    fail_count_d     = '0;
                    first_fail_idx_d = '0;
                    timeout_flag_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                aes_key_d = vec_key;
                aes_pt_d  = vec_pt;
                tmo_d     = '0;
                to_hit_d  = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A result on the final wait cycle beats the timeout.
                if (aes_valid) begin
                    ct_d    = aes_ct;
                    state_d = S_CHECK;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    to_hit_d       = 1'b1;
                    timeout_flag_d = 1'b1;
                    state_d        = S_CHECK;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_CHECK: begin
                if (mismatch_c) begin
                    if (fail_count_q != '1) begin
                        fail_count_d = fail_count_q + CNT_W'(1);
                    end
                    if (fail_count_q == '0) begin
                        first_fail_idx_d = vec_idx_q;
                    end
                end
                if (last_c || stop_c) begin
                    state_d = S_DONE;
                end else begin
                    vec_idx_d = vec_idx_q + IDX_W'(1);
                    state_d   = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered.
        aes_req_d = (state_d == S_ISSUE);
        busy_d    = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d    = (state_d == S_DONE);
        pass_d    = done_d && (fail_count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            vec_idx_q        <= '0;
            aes_key_q        <= '0;
            aes_pt_q         <= '0;
            aes_req_q        <= 1'b0;
            ct_q             <= '0;
            tmo_q            <= '0;
            to_hit_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_count_q     <= '0;
            first_fail_idx_q <= '0;
            timeout_flag_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_idx_q        <= vec_idx_d;
            aes_key_q        <= aes_key_d;
            aes_pt_q         <= aes_pt_d;
            aes_req_q        <= aes_req_d;
            ct_q             <= ct_d;
            tmo_q            <= tmo_d;
            to_hit_q         <= to_hit_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            fail_count_q     <= fail_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            timeout_flag_q   <= timeout_flag_d;
        end
    end

    assign vec_idx        = vec_idx_q;
    assign aes_req        = aes_req_q;
    assign aes_key        = aes_key_q;
    assign aes_pt         = aes_pt_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign timeout_flag   = timeout_flag_q;

endmodule

// File: tb/tb_aes_kat_checker.sv
// Self-checking bench for aes_kat_checker: vector ROM, latency-programmable core model, run-result scoreboard.
`timescale 1ns/1ps
module tb_aes_kat_checker;

    localparam int unsigned NV      = 4;
    localparam int unsigned TMO     = 64;
    localparam int unsigned DW      = 128;
    localparam int unsigned IW      = 2;
    localparam int          MAX_CYC = 400;

    localparam logic [DW-1:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DW-1:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [DW-1:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [DW-1:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [DW-1:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic          clk, rst, start;
    logic [IW-1:0] vec_idx;
    logic [DW-1:0] vec_key, vec_pt, vec_ct;
    logic          aes_req, aes_valid;
    logic [DW-1:0] aes_key, aes_pt, aes_ct;
    logic          busy, done, pass, timeout_flag;
    logic [IW:0]   fail_count;
    logic [IW-1:0] first_fail_idx;

    logic [DW-1:0] rom_key [NV];
    logic [DW-1:0] rom_pt  [NV];
    logic [DW-1:0] rom_ct  [NV];

    logic core_valid, spur_valid, core_mute;
    int   core_lat;
    int   checks, fails;

    typedef struct {
        logic        pass;
        logic [IW:0] fc;
        logic [IW-1:0] ffi;
        logic        to;
        int          nreq;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    assign vec_key   = rom_key[vec_idx];
    assign vec_pt    = rom_pt[vec_idx];
    assign vec_ct    = rom_ct[vec_idx];
    assign aes_valid = core_valid | spur_valid;

    aes_kat_checker #(.NUM_VECTORS(NV), .TIMEOUT_CYCLES(TMO), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .vec_idx(vec_idx), .vec_key(vec_key), .vec_pt(vec_pt), .vec_ct(vec_ct),
        .aes_req(aes_req), .aes_key(aes_key), .aes_pt(aes_pt),
        .aes_valid(aes_valid), .aes_ct(aes_ct),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .timeout_flag(timeout_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] aes_model(input logic [DW-1:0] k, input logic [DW-1:0] p);
        if (k == K1 && p == P1) return C1;
        if (k == K2 && p == P2) return C2;
        return k ^ p;
    endfunction

    // Core model: answers core_lat cycles after the request cycle, abandons on reset.
    initial begin
        int n;
        core_valid = 1'b0;
        aes_ct     = '0;
        forever begin
            @(negedge clk);
            if (rst && aes_req && !core_mute) begin
                n = 0;
                while (n < core_lat && rst) begin
                    @(posedge clk);
                    n++;
                end
                if (rst) begin
                    #1;
                    core_valid = 1'b1;
                    aes_ct     = aes_model(aes_key, aes_pt);
                    @(posedge clk);
                    #1;
                    core_valid = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom_c1();
        for (int i = 0; i < int'(NV); i++) begin
            rom_key[i] = K1;
            rom_pt[i]  = P1;
            rom_ct[i]  = C1;
        end
    endtask

    function automatic exp_t mk_exp(input logic p, input int fc, input int ffi, input logic to,
                                    input int nreq, input int lat);
        exp_t e;
        e.pass = p;
        e.fc   = (IW+1)'(fc);
        e.ffi  = IW'(ffi);
        e.to   = to;
        e.nreq = nreq;
        e.lat  = lat;
        return e;
    endfunction

    // Called at the negedge of the first cycle after the start edge; follows the run to done.
    task automatic collect(input string tag);
        exp_t e;
        int   cyc, nreq, k;
        bit   prev_req;
        check({tag, ".started"}, DW'({busy, done, aes_req, timeout_flag}), DW'(4'b1010));
        check({tag, ".cleared"}, DW'(fail_count), DW'(0));
        cyc = 1; nreq = 0; k = 0; prev_req = 1'b0;
        while (cyc <= MAX_CYC) begin
            if (prev_req && k < int'(NV)) begin
                check($sformatf("%s.key%0d", tag, k), aes_key, rom_key[k]);
                check($sformatf("%s.pt%0d", tag, k), aes_pt, rom_pt[k]);
                k++;
            end
            if (aes_req) nreq++;
            prev_req = aes_req;
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        check({tag, ".done"}, DW'(done), DW'(1));
        check({tag, ".latency"}, DW'(cyc), DW'(e.lat));
        check({tag, ".req_pulses"}, DW'(nreq), DW'(e.nreq));
        check({tag, ".pass"}, DW'(pass), DW'(e.pass));
        check({tag, ".fail_count"}, DW'(fail_count), DW'(e.fc));
        check({tag, ".first_fail_idx"}, DW'(first_fail_idx), DW'(e.ffi));
        check({tag, ".timeout_flag"}, DW'(timeout_flag), DW'(e.to));
        check({tag, ".busy_low"}, DW'(busy), DW'(0));
    endtask

    task automatic run_kat(input string tag, input exp_t e, input bit hold);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        collect(tag);
    endtask

    initial begin
        checks = 0; fails = 0;
        rst = 1'b0; start = 1'b0; spur_valid = 1'b0;
        core_mute = 1'b0; core_lat = 11;
        fill_rom_c1();

        repeat (3) @(negedge clk);
        check("rst.busy_done_req", DW'({busy, done, aes_req, pass, timeout_flag}), DW'(0));
        check("rst.vec_idx", DW'(vec_idx), DW'(0));
        check("rst.fail_count", DW'(fail_count), DW'(0));
        check("rst.first_fail_idx", DW'(first_fail_idx), DW'(0));
        check("rst.aes_key", aes_key, DW'(0));
        check("rst.aes_pt", aes_pt, DW'(0));
        rst = 1'b1;

        // Spurious result strobe while idle
        @(negedge clk);
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_spur.state", DW'({busy, done, aes_req, pass, timeout_flag}), DW'(0));
        check("idle_spur.fail_count", DW'(fail_count), DW'(0));

        // Four FIPS-197 C.1 vectors, all match
`ifdef AES_KAT_STOP_ON_FAIL_EN
        run_kat("c1_all", mk_exp(1'b1, 0, 0, 1'b0, 4, 53), 1'b0);
`else
        run_kat("c1_all", mk_exp(1'b1, 0, 0, 1'b0, 4, 53), 1'b0);
`endif

        // Vector 2 is the FIPS-197 B vector with a corrupted expected ciphertext
        rom_key[2] = K2;
        rom_pt[2]  = P2;
        rom_ct[2]  = C2 ^ 128'hff;
`ifdef AES_KAT_STOP_ON_FAIL_EN
        run_kat("corrupt_v2", mk_exp(1'b0, 1, 2, 1'b0, 3, 40), 1'b0);
`else
        run_kat("corrupt_v2", mk_exp(1'b0, 1, 2, 1'b0, 4, 53), 1'b0);
`endif

        // Silent core: every vector times out
        fill_rom_c1();
        core_mute = 1'b1;
`ifdef AES_KAT_STOP_ON_FAIL_EN
        run_kat("timeout_all", mk_exp(1'b0, 1, 0, 1'b1, 1, 67), 1'b0);
`else
        run_kat("timeout_all", mk_exp(1'b0, 4, 0, 1'b1, 4, 265), 1'b0);
`endif
        core_mute = 1'b0;

        // Result arrives on exactly the last wait cycle
        core_lat = 64;
        run_kat("valid_at_timeout", mk_exp(1'b1, 0, 0, 1'b0, 4, 265), 1'b0);
        core_lat = 11;

        // Reset in the middle of vector 1's wait
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        check("midrst.in_wait_v1", DW'({busy, vec_idx}), DW'(3'b101));
        rst = 1'b0;
        #1;
        check("midrst.flags_zero", DW'({busy, done, aes_req, pass, timeout_flag}), DW'(0));
        check("midrst.vec_idx", DW'(vec_idx), DW'(0));
        check("midrst.aes_key", aes_key, DW'(0));
        check("midrst.aes_pt", aes_pt, DW'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_kat("after_rst", mk_exp(1'b1, 0, 0, 1'b0, 4, 53), 1'b0);

        // Failing run, then start from DONE must clear its status
        rom_ct[1] = C1 ^ 128'h1;
`ifdef AES_KAT_STOP_ON_FAIL_EN
        run_kat("fail_v1", mk_exp(1'b0, 1, 1, 1'b0, 2, 27), 1'b0);
`else
        run_kat("fail_v1", mk_exp(1'b0, 1, 1, 1'b0, 4, 53), 1'b0);
`endif
        rom_ct[1] = C1;

        // Start held high: ignored while busy, restarts from DONE
        run_kat("hold_start", mk_exp(1'b1, 0, 0, 1'b0, 4, 53), 1'b1);
        @(negedge clk);
        start = 1'b0;
        sb_q.push_back(mk_exp(1'b1, 0, 0, 1'b0, 4, 53));
        collect("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
